// File: rtl/elevator_ctrl_n.sv
// Parametrised SCAN elevator controller: latches floor calls, picks the next stop
// in the current sweep direction, and times travel and door dwell from a 1 Hz tick.
module elevator_ctrl_n #(
    parameter int FLOORS       = 4,
    parameter int FLOOR_W      = $clog2(FLOORS),
    parameter int TRAVEL_TICKS = 3,
    parameter int DOOR_TICKS   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic [FLOORS-1:0]  req,
    input  logic               emerg_in,
    output logic [FLOOR_W-1:0] cur_floor,
    output logic [FLOOR_W-1:0] next_floor,
    output logic [2:0]         motor,
    output logic               door_open,
    output logic               emerg_out,
    output logic [FLOORS-1:0]  pending
);

    localparam int TW = (TRAVEL_TICKS > 1) ? $clog2(TRAVEL_TICKS) : 1;
    localparam int DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_TICKS - 1);
    localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_TICKS - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS - 1);

    localparam logic [2:0] MOTOR_UP    = 3'b100;
    localparam logic [2:0] MOTOR_DOWN  = 3'b010;
    localparam logic [2:0] MOTOR_BRAKE = 3'b001;

    typedef enum logic [1:0] {IDLE, MOVE, DOOR, EMERG} state_t;

    state_t             state;
    logic               dir;
    logic [TW-1:0]      travel_cnt;
    logic [DW-1:0]      door_cnt;

    logic               above_found;
    logic               below_found;
    logic [FLOOR_W-1:0] above_floor;
    logic [FLOOR_W-1:0] below_floor;
    logic [FLOOR_W-1:0] sel_floor;
    logic               sel_dir;
    logic               arrive;
    logic [FLOOR_W-1:0] arr_floor;
    logic [FLOORS-1:0]  pending_nxt;

    // SCAN selection: nearest call ahead in the sweep, otherwise the nearest call behind
    // (which reverses the sweep); with no calls the target is the current floor.
    always_comb begin
        above_found = 1'b0;
        below_found = 1'b0;
        above_floor = cur_floor;
        below_floor = cur_floor;
        for (int i = FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (FLOOR_W'(i) > cur_floor)) begin
                above_found = 1'b1;
                above_floor = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < FLOORS; i++) begin
            if (pending[i] && (FLOOR_W'(i) < cur_floor)) begin
                below_found = 1'b1;
                below_floor = FLOOR_W'(i);
            end
        end
        sel_floor = cur_floor;
        sel_dir   = dir;
        if (dir) begin
            if (above_found) begin
                sel_floor = above_floor;
            end else if (below_found) begin
                sel_floor = below_floor;
                sel_dir   = 1'b0;
            end
        end else begin
            if (below_found) begin
                sel_floor = below_floor;
            end else if (above_found) begin
                sel_floor = above_floor;
                sel_dir   = 1'b1;
            end
        end
    end

    // Arrival at the next landing; the car never runs past either end of the shaft.
    always_comb begin
        arrive = (state == MOVE) && tick && (travel_cnt == TRAVEL_LAST);
        if (dir) begin
            arr_floor = (cur_floor == TOP_FLOOR) ? cur_floor : cur_floor + FLOOR_W'(1);
        end else begin
            arr_floor = (cur_floor == '0) ? cur_floor : cur_floor - FLOOR_W'(1);
        end
    end

    // Call latching; the floor being served is cleared, and that clear beats a new press.
    always_comb begin
        pending_nxt = pending | req;
        case (state)
            IDLE: begin
                if (pending[cur_floor]) pending_nxt[cur_floor] = 1'b0;
            end
            MOVE: begin
                if (arrive && pending[arr_floor]) pending_nxt[arr_floor] = 1'b0;
            end
            DOOR: begin
                pending_nxt[cur_floor] = 1'b0;
            end
            EMERG: begin
                pending_nxt = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            dir        <= 1'b1;
            cur_floor  <= '0;
            next_floor <= '0;
            pending    <= '0;
            motor      <= MOTOR_BRAKE;
            door_open  <= 1'b0;
            emerg_out  <= 1'b0;
            travel_cnt <= '0;
            door_cnt   <= '0;
        end else if (emerg_in) begin
            state      <= EMERG;
            motor      <= MOTOR_BRAKE;
            door_open  <= 1'b0;
            emerg_out  <= 1'b1;
            pending    <= '0;
            travel_cnt <= '0;
            door_cnt   <= '0;
            next_floor <= cur_floor;
        end else begin
            next_floor <= sel_floor;
            dir        <= sel_dir;
            pending    <= pending_nxt;
            case (state)
                IDLE: begin
                    if (pending[cur_floor]) begin
                        state     <= DOOR;
                        door_open <= 1'b1;
                        door_cnt  <= '0;
                        motor     <= MOTOR_BRAKE;
                    end else if (|pending) begin
                        state      <= MOVE;
                        travel_cnt <= '0;
                        motor      <= sel_dir ? MOTOR_UP : MOTOR_DOWN;
                    end
                end
                MOVE: begin
                    if (arrive) begin
                        travel_cnt <= '0;
                        cur_floor  <= arr_floor;
                        if (pending[arr_floor]) begin
                            state     <= DOOR;
                            motor     <= MOTOR_BRAKE;
                            door_open <= 1'b1;
                            door_cnt  <= '0;
                        end
                    end else if (tick) begin
                        travel_cnt <= travel_cnt + TW'(1);
                    end
                end
                DOOR: begin
                    // A fresh press at this landing holds the door for a full dwell again.
                    if (req[cur_floor]) begin
                        door_cnt <= '0;
                    end else if (tick) begin
                        if (door_cnt == DOOR_LAST) begin
                            state     <= IDLE;
                            door_open <= 1'b0;
                            door_cnt  <= '0;
                        end else begin
                            door_cnt <= door_cnt + DW'(1);
                        end
                    end
                end
                EMERG: begin
                    state     <= IDLE;
                    emerg_out <= 1'b0;
                    motor     <= MOTOR_BRAKE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Bench for elevator_ctrl_n: directed cycle checks plus a scoreboard of the floors
// at which the door is expected to open, in order.
module tb_elevator_ctrl_n;

    logic       clk;
    logic       reset;
    logic       tick;
    logic [3:0] req;
    logic       emerg_in;
    logic [1:0] cur_floor;
    logic [1:0] next_floor;
    logic [2:0] motor;
    logic       door_open;
    logic       emerg_out;
    logic [3:0] pending;

    int checkCount = 0;
    int errorCount = 0;
    int sbQ[$];
    logic doorPrev = 1'b0;

    elevator_ctrl_n #(
        .FLOORS(4),
        .TRAVEL_TICKS(2),
        .DOOR_TICKS(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tick(tick),
        .req(req),
        .emerg_in(emerg_in),
        .cur_floor(cur_floor),
        .next_floor(next_floor),
        .motor(motor),
        .door_open(door_open),
        .emerg_out(emerg_out),
        .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulse a call mask for one clock and record which door openings it should cause.
    task automatic applyStimulus(input logic [3:0] mask, input int exp0, input int exp1);
        if (exp0 >= 0) sbQ.push_back(exp0);
        if (exp1 >= 0) sbQ.push_back(exp1);
        req = mask;
        cyc(1);
        req = 4'b0000;
    endtask

    task automatic waitFloor(input int floor, input int budget);
        int n = 0;
        while ((cur_floor != floor) && (n < budget)) begin
            cyc(1);
            n++;
        end
        if (cur_floor != floor) checkOutput("wait_floor_timeout", cur_floor, floor);
    endtask

    task automatic waitDoor(input int budget);
        int n = 0;
        while (!door_open && (n < budget)) begin
            cyc(1);
            n++;
        end
        while (door_open && (n < budget)) begin
            cyc(1);
            n++;
        end
        if (n >= budget) checkOutput("wait_door_timeout", n, 0);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_cur"}, cur_floor, 0);
        checkOutput({tag, "_next"}, next_floor, 0);
        checkOutput({tag, "_motor"}, motor, 3'b001);
        checkOutput({tag, "_door"}, door_open, 0);
        checkOutput({tag, "_emerg"}, emerg_out, 0);
        checkOutput({tag, "_pending"}, pending, 0);
    endtask

    // Each rising door edge must be at the floor at the head of the expected queue.
    always @(negedge clk) begin
        int expFloor;
        if (door_open && !doorPrev) begin
            expFloor = (sbQ.size() > 0) ? sbQ.pop_front() : 15;
            checkOutput("door_floor", cur_floor, expFloor);
        end
        doorPrev = door_open;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        tick = 1'b0;
        req = 4'b0000;
        emerg_in = 1'b0;
        #2 reset = 1'b0;
        #1;
        checkReset("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick = 1'b1;

        // Call at the floor the car already rests on: door opens without motion.
        applyStimulus(4'b0001, 0, -1);
        checkOutput("f0_pending", pending, 4'b0001);
        checkOutput("f0_motor_a", motor, 3'b001);
        cyc(1);
        checkOutput("f0_door_open", door_open, 1);
        checkOutput("f0_pending_clr", pending, 0);
        checkOutput("f0_motor_b", motor, 3'b001);
        cyc(1);
        checkOutput("f0_door_hold", door_open, 1);
        checkOutput("f0_motor_c", motor, 3'b001);
        cyc(1);
        checkOutput("f0_door_close", door_open, 0);

        // Trip 0 -> 2, two ticks per floor, two-tick dwell.
        applyStimulus(4'b0100, 2, -1);
        checkOutput("t1_pending", pending, 4'b0100);
        checkOutput("t1_motor_idle", motor, 3'b001);
        cyc(1);
        checkOutput("t1_motor_up", motor, 3'b100);
        checkOutput("t1_next", next_floor, 2);
        cyc(1);
        checkOutput("t1_cur_a", cur_floor, 0);
        cyc(1);
        checkOutput("t1_cur_b", cur_floor, 1);
        cyc(1);
        checkOutput("t1_cur_c", cur_floor, 1);
        cyc(1);
        checkOutput("t1_cur_d", cur_floor, 2);
        checkOutput("t1_door", door_open, 1);
        checkOutput("t1_brake", motor, 3'b001);
        checkOutput("t1_pending_clr", pending, 0);
        cyc(1);
        checkOutput("t1_door_hold", door_open, 1);
        cyc(1);
        checkOutput("t1_door_close", door_open, 0);

        // Back down to 0, then up toward 3 with a call for 2 added on the way.
        applyStimulus(4'b0001, 0, -1);
        waitDoor(40);
        checkOutput("t3_at0", cur_floor, 0);
        applyStimulus(4'b1000, -1, -1);
        waitFloor(1, 40);
        applyStimulus(4'b0100, 2, 3);
        checkOutput("t3_pending", pending, 4'b1100);
        cyc(1);
        checkOutput("t3_stop2", cur_floor, 2);
        checkOutput("t3_door2", door_open, 1);
        cyc(1);
        checkOutput("t3_door2_hold", door_open, 1);
        // Re-press floor 2 on the last dwell tick: door stays for two more ticks.
        applyStimulus(4'b0100, -1, -1);
        checkOutput("t5_reopen", door_open, 1);
        checkOutput("t5_pending", pending, 4'b1000);
        cyc(1);
        checkOutput("t5_reopen_hold", door_open, 1);
        cyc(1);
        checkOutput("t5_reopen_close", door_open, 0);
        waitDoor(40);
        checkOutput("t3_at3", cur_floor, 3);

        // From 3 with nothing above, a call for 0 reverses the sweep.
        applyStimulus(4'b0001, 0, -1);
        cyc(1);
        checkOutput("t3_next_flip", next_floor, 0);
        checkOutput("t3_motor_down", motor, 3'b010);
        waitDoor(60);
        checkOutput("t3_at0_again", cur_floor, 0);

        // Emergency stop halfway between floors 1 and 2.
        applyStimulus(4'b1000, -1, -1);
        waitFloor(1, 40);
        cyc(1);
        emerg_in = 1'b1;
        cyc(1);
        checkOutput("em_out", emerg_out, 1);
        checkOutput("em_motor", motor, 3'b001);
        checkOutput("em_pending", pending, 0);
        checkOutput("em_cur", cur_floor, 1);
        checkOutput("em_door", door_open, 0);
        req = 4'b0100;
        cyc(1);
        req = 4'b0000;
        checkOutput("em_req_ignored", pending, 0);
        emerg_in = 1'b0;
        cyc(1);
        checkOutput("em_release", emerg_out, 0);
        checkOutput("em_release_pending", pending, 0);
        cyc(3);
        checkOutput("em_still_cur", cur_floor, 1);
        checkOutput("em_still_motor", motor, 3'b001);

        // Tick held low freezes travel; then an asynchronous reset mid-move.
        applyStimulus(4'b1000, -1, -1);
        waitFloor(2, 40);
        tick = 1'b0;
        cyc(5);
        checkOutput("frz_cur", cur_floor, 2);
        checkOutput("frz_motor", motor, 3'b100);
        tick = 1'b1;
        cyc(1);
        checkOutput("frz_resume_cur", cur_floor, 2);
        reset = 1'b0;
        #1;
        checkReset("midreset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(3);
        checkOutput("post_reset_cur", cur_floor, 0);
        checkOutput("post_reset_motor", motor, 3'b001);
        checkOutput("post_reset_pending", pending, 0);

        checkOutput("sb_drained", sbQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/elevator_ctrl_n.md
# elevator_ctrl_n

Parametrised elevator controller for FLOORS landings: latches floor-call requests, schedules service in SCAN order, times travel and door dwell from a 1 Hz tick, and drives motor, door and emergency outputs. Successor to the fixed three-floor FSM. Sits between the clock divider, which supplies `tick`, and the display multiplexer and motor driver, which consume `cur_floor` and `next_floor`.

## Interface
- FLOORS, 4: number of landings, 2..16.
- FLOOR_W, $clog2(FLOORS): floor index width.
- TRAVEL_TICKS, 3: ticks to move one floor, ≥1.
- DOOR_TICKS, 2: ticks door stays open, ≥1.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- tick  in  1  one-clk enable pulse from the clock divider; all timing counts advance only on tick.
- req  in  FLOORS  floor-call buttons; any clk-high bit is latched.
- emerg_in  in  1  emergency stop, level.
- cur_floor  out  FLOOR_W  current or last-passed floor.
- next_floor  out  FLOOR_W  current target floor; equals cur_floor when no target.
- motor  out  3  {up, down, brake}, one-hot.
- door_open  out  1  door open.
- emerg_out  out  1  high in EMERG state.
- pending  out  FLOORS  latched, unserved requests.

## Operation
- Reset values: state IDLE, cur_floor=0, next_floor=0, dir=up, pending=0, motor=3'b001, door_open=0, emerg_out=0, all counters 0.
- Latching: `pending <= pending | req` each clk. The bit for a floor being served clears at DOOR entry, and that clear wins over a same-cycle req for the same floor. A req bit at or above FLOORS does not exist.
- Target selection uses SCAN:
  - dir=up: lowest pending floor above cur_floor. If none, highest pending floor below cur_floor, and dir flips to down.
  - dir=down mirrors this.
  - next_floor is registered from this selection every clk.
- IDLE: motor=brake.
  - pending[cur_floor]=1 → DOOR, clear bit.
  - Otherwise, any pending → MOVE in the selected direction.
  - Otherwise, stay.
- MOVE: motor=up or down per dir.
  - travel_cnt increments on tick.
  - At TRAVEL_TICKS-1 with tick: cur_floor ±1, travel_cnt=0.
  - On arrival, pending[new floor]=1 → DOOR, clear bit. Otherwise continue in MOVE.
  - cur_floor saturates at 0 and FLOORS-1; a request can never drive it past either end.
- DOOR: door_open=1, motor=brake.
  - door_cnt increments on tick; at DOOR_TICKS-1 with tick → IDLE.
  - A req for cur_floor during DOOR clears immediately and reloads door_cnt=0.
- EMERG: entered from any state on emerg_in=1 and has highest priority.
  - motor=brake, door_open=0, emerg_out=1, pending cleared; req is ignored while in EMERG.
  - travel_cnt and door_cnt reset to 0. cur_floor holds its last value: a mid-floor stop reports the last-passed floor.
  - On emerg_in=0 → IDLE the next clk.

## Timing
- All outputs are registered.
- req to pending visibility: 1 clk.
- IDLE to MOVE/DOOR decision: 1 clk after pending is visible.
- emerg_in to emerg_out/brake: 1 clk, from any state and regardless of tick.
- Floor-to-floor travel: exactly TRAVEL_TICKS ticks. Door dwell: exactly DOOR_TICKS ticks.
- When tick and a state change coincide, the state change takes effect and the counter of the newly entered state starts at 0.
- Reset asserted mid-operation: all outputs return to reset values asynchronously; no pending state survives.
- Simultaneous requests above and below while IDLE: current dir is honoured first.

## Test plan
- Reset, then FLOORS=4, TRAVEL_TICKS=2, DOOR_TICKS=2, tick every clk; pulse req=4'b0100 → pending=0100 next clk; MOVE up; cur_floor reaches 1 then 2, each 2 ticks apart; door_open high for 2 ticks; pending=0; returns to IDLE.
- At floor 0 idle, pulse req=4'b0001 → DOOR immediately, motor never leaves brake.
- At floor 1 moving up toward 3, add req floor 2 → stops at 2 first; then 3. Then req floor 0 → dir flips down, next_floor=0.
- Assert emerg_in mid-travel between floors 1 and 2 → next clk emerg_out=1, motor=001, pending=0, cur_floor=1; deassert → IDLE, no motion.
- During DOOR at floor 2, re-press req floor 2 → door_cnt restarts; door open for 2 further ticks.
- Hold tick=0 in MOVE → cur_floor and travel_cnt frozen; assert reset (low) mid-MOVE → all outputs at reset values immediately.
